muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
// - Iterative RV32M multiply/divide unit; the multi-cycle companion to the single-cycle ALU in EX stage.
// - Accepts one op via valid/ready; produces one result via valid/ready.
// - Pipeline stalls EX while busy_o=1.
// - Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// PARAMETERS
// - Width  32  operand/result width (>=8, even)
// - CntW   $clog2(Width)  iteration counter width (derived, do not override)
// PORTS
// - clk_i      in   1      clock; all state on rising edge
// - rst_ni     in   1      synchronous reset, active-low
// - DataA      in   Width  operand rs1 (multiplicand / dividend)
// - DataB      in   Width  operand rs2 (multiplier / divisor)
// - MulDivSel  in   3      0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
// - valid_i    in   1      request valid
// - ready_o    out  1      unit can accept (=1 only in IDLE)
// - flush_i    in   1      abort in-flight op (branch mispredict / trap)
// - valid_o    out  1      result valid; held until ready_i
// - ready_i    in   1      consumer takes result
// - result_o   out  Width  result; 0 when valid_o=0
// - busy_o     out  1      1 in CALC or DONE
// BEHAVIOUR
// - Reset (rst_ni=0 at edge): state IDLE, counter 0, internal regs 0.
//   - Reset outputs: ready_o=1, valid_o=0, busy_o=0, result_o=0.
//   - Reset mid-operation discards the op; no result is ever emitted.
// - FSM: IDLE -> CALC -> DONE -> IDLE.
//   - IDLE: accept on valid_i&ready_o; latch op, |operands|, sign flags; counter=Width-1.
//   - CALC: one iteration per cycle; at counter==0 go DONE, else counter-1.
//   - DONE: valid_o=1; on ready_i go IDLE (no new accept in the same cycle).
// - Latency: op accepted at edge k -> CALC cycles k+1..k+Width; valid_o from cycle k+Width+1.
// - Sign handling: operands converted to magnitude per op signedness.
//   - MULHSU: only DataA signed.
//   - Result negated at DONE entry if signs differ (quotient) or dividend negative (remainder).
// - MUL returns low Width bits of 2*Width product; MULH/MULHSU/MULHU return high Width bits.
// - Fast path (IDLE -> DONE, valid_o at k+1, no CALC):
//   - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> DataA.
//   - Signed overflow, DataA=-2^(Width-1) and DataB=-1: DIV -> DataA; REM -> 0.
// - flush_i=1 in CALC or DONE -> IDLE next cycle; valid_o drops; result discarded.
// - flush_i in IDLE: no effect; a valid_i in the same cycle is NOT accepted.
// - rst_ni has priority over flush_i; flush_i has priority over ready_i.
// - valid_o=1 && ready_i=0: result_o and valid_o stable until ready_i.
// CONFIGURATION
// - MULDIV_FAST_MUL_EN defined:
//   - MUL* ops use a single-cycle combinational 2*Width multiplier.
//   - IDLE -> DONE directly; valid_o at k+1.
//   - Divide path unchanged.
// - MULDIV_FAST_MUL_EN undefined: all ops iterative, latency as above; no multiplier inferred.
// TESTING (Width=32)
// - MUL 7*-3 -> result_o=0xFFFFFFEB, valid_o at k+33 (k+1 with MULDIV_FAST_MUL_EN).
// - MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
// - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
// - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
// - DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000; each valid_o at k+1.
// - Backpressure: hold ready_i=0 for 5 cycles in DONE -> result stable, ready_o=0.
//   - Then ready_i=1 -> IDLE next cycle.
// - flush_i at CALC cycle 10 -> no valid_o.
//   - rst_ni=0 at CALC cycle 5 -> ready_o=1, valid_o=0 next cycle.
//   - Next op completes correctly after either.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/result handshake bundle for muldiv_unit.
// master: issuing pipeline stage and result consumer; slave: the unit.
interface muldiv_unit_if #(
    parameter int Width = 32
);
    logic [Width-1:0] DataA;
    logic [Width-1:0] DataB;
    logic [2:0]       MulDivSel;
    logic             valid_i;
    logic             ready_o;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic [Width-1:0] result_o;
    logic             busy_o;

    modport master (
        output DataA, DataB, MulDivSel, valid_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, busy_o
    );

    modport slave (
        input  DataA, DataB, MulDivSel, valid_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, busy_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Latency Width+1 cycles to valid_o (1 for divide-by-zero/overflow); ready_o only in IDLE, result held until ready_i.
// MULDIV_FAST_MUL_EN: MUL* ops use a single-cycle combinational multiplier instead of the iterative path.
module muldiv_unit #(
    parameter int Width = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    muldiv_unit_if.slave bus
);
    localparam int CntW = $clog2(Width);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [Width-1:0]  dvsr_q;
    logic [Width-1:0]  hi_q;
    logic [Width-1:0]  lo_q;
    logic [CntW-1:0]   cnt_q;
    logic [Width-1:0]  result_q;
    logic              valid_q;
    logic              ready_q;
    logic              busy_q;

    assign bus.ready_o  = ready_q;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
    assign bus.busy_o   = busy_q;

    function automatic logic [Width-1:0] mul_result(input logic [2:0] op, input logic neg,
                                                    input logic [2*Width-1:0] prod);
        logic [2*Width-1:0] p;
        p = neg ? -prod : prod;
        return (op == OP_MUL) ? p[Width-1:0] : p[2*Width-1:Width];
    endfunction

    // Incoming operand decode
    logic             a_sgn, b_sgn;
    logic             a_neg, b_neg;
    logic [Width-1:0] a_mag, b_mag;
    logic             neg_in;
    logic             div0, ovf, fast_div;
    logic [Width-1:0] fast_res;
    logic             accept;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (bus.MulDivSel)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            OP_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign a_neg  = a_sgn & bus.DataA[Width-1];
    assign b_neg  = b_sgn & bus.DataB[Width-1];
    assign a_mag  = a_neg ? -bus.DataA : bus.DataA;
    assign b_mag  = b_neg ? -bus.DataB : bus.DataB;
    // Remainder takes the dividend's sign; quotient and products the sign difference
    assign neg_in = (bus.MulDivSel[2] & bus.MulDivSel[1]) ? a_neg : (a_neg ^ b_neg);

    assign div0     = (bus.DataB == '0);
    assign ovf      = ~bus.MulDivSel[0] &
                      (bus.DataA == {1'b1, {(Width-1){1'b0}}}) & (bus.DataB == '1);
    assign fast_div = bus.MulDivSel[2] & (div0 | ovf);
    assign accept   = bus.valid_i & ready_q & ~bus.flush_i;

    always_comb begin
        if (div0) fast_res = bus.MulDivSel[1] ? bus.DataA : '1;
        else      fast_res = bus.MulDivSel[1] ? '0 : bus.DataA;
    end

    // One iteration: hi/lo hold {partial product, multiplier} or {remainder, quotient}
    logic [Width:0]   mul_sum;
    logic [Width:0]   rem_sh;
    logic [Width+1:0] diff;
    logic [Width-1:0] hi_nxt, lo_nxt;
    logic [Width-1:0] calc_res;

    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvsr_q} : '0);
    assign rem_sh  = {hi_q, lo_q[Width-1]};
    assign diff    = {1'b0, rem_sh} - {2'b00, dvsr_q};

    always_comb begin
        if (!op_q[2]) begin
            hi_nxt = mul_sum[Width:1];
            lo_nxt = {mul_sum[0], lo_q[Width-1:1]};
        end else if (!diff[Width+1]) begin
            hi_nxt = diff[Width-1:0];
            lo_nxt = {lo_q[Width-2:0], 1'b1};
        end else begin
            hi_nxt = rem_sh[Width-1:0];
            lo_nxt = {lo_q[Width-2:0], 1'b0};
        end
    end

    always_comb begin
        if (!op_q[2])    calc_res = mul_result(op_q, neg_q, {hi_nxt, lo_nxt});
        else if (op_q[1]) calc_res = neg_q ? -hi_nxt : hi_nxt;
        else             calc_res = neg_q ? -lo_nxt : lo_nxt;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [Width-1:0] fast_mul_res;
    assign fast_mul_res = mul_result(bus.MulDivSel, neg_in, a_mag * b_mag);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            dvsr_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= bus.MulDivSel;
                        neg_q   <= neg_in;
                        cnt_q   <= CntW'(Width-1);
                        hi_q    <= '0;
                        dvsr_q  <= bus.MulDivSel[2] ? b_mag : a_mag;
                        lo_q    <= bus.MulDivSel[2] ? a_mag : b_mag;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (fast_div) begin
                            state    <= DONE;
                            result_q <= fast_res;
                            valid_q  <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!bus.MulDivSel[2]) begin
                            state    <= DONE;
                            result_q <= fast_mul_res;
                            valid_q  <= 1'b1;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush_i) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        hi_q <= hi_nxt;
                        lo_q <= lo_nxt;
                        if (cnt_q == '0) begin
                            state    <= DONE;
                            result_q <= calc_res;
                            valid_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CntW'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.flush_i || bus.ready_i) begin
                        state    <= IDLE;
                        result_q <= '0;
                        valid_q  <= 1'b0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    result_q <= '0;
                    valid_q  <= 1'b0;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule
